switch_ingress_fifo: RTL
========================

# switch_ingress_fifo

Buffered ingress stage that sits directly upstream of the two-way address switch and drives its `vld`/`addr`/`data` inputs. It accepts transactions from a producer over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It then issues them to the switch as single-cycle `vld` pulses, with optional throttling (`out_en`) and a programmable inter-issue gap. It also keeps wrapping per-destination issue counters, split at ADDR_DIV exactly as the switch routes.

## Interface
- ADDR_WIDTH, 8, address width (matches switch).
- DATA_WIDTH, 16, data width (matches switch).
- DEPTH, 8, FIFO entries; power of two, ≥ 2.
- GAP, 0, idle cycles forced after each issue; 0 allows back-to-back issue.
- ADDR_DIV, 8'h3F, last address counted as port A; higher addresses count as port B.
- clk  input  1  clock; all logic on posedge.
- rstn  input  1  reset, synchronous, active-low.
- in_vld  input  1  producer has a transaction.
- in_rdy  output  1  FIFO can accept; equals !full.
- in_addr  input  ADDR_WIDTH  transaction address.
- in_data  input  DATA_WIDTH  transaction data.
- out_en  input  1  downstream issue enable; low stalls issue.
- out_vld  output  1  one-cycle issue strobe to switch `vld`.
- out_addr  output  ADDR_WIDTH  to switch `addr`.
- out_data  output  DATA_WIDTH  to switch `data`.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- a_cnt  output  16  issues with addr ≤ ADDR_DIV; wraps 16'hFFFF→0.
- b_cnt  output  16  issues with addr > ADDR_DIV; wraps.

## Operation
- Push: on an edge where in_vld && in_rdy, write {in_addr,in_data} at wr_ptr and advance wr_ptr modulo DEPTH.
- in_rdy is low when full, even if a pop occurs in the same cycle. There is no full-pass-through.
- Pop condition: !empty && out_en && gap_cnt == 0.
- On a pop edge:
  - Load the head entry into out_addr/out_data, set out_vld=1, and advance rd_ptr.
  - Load gap_cnt with GAP.
  - Increment a_cnt if addr ≤ ADDR_DIV, else increment b_cnt.
- Any edge without a pop:
  - out_vld=0; out_addr/out_data hold their last values.
  - gap_cnt decrements if nonzero. It decrements regardless of out_en.
- Simultaneous push and pop: count unchanged; both pointers advance.
- No empty bypass: a word pushed on edge k is popped no earlier than edge k+1.
- Pointers use an extra wrap bit; full/empty are derived from pointer compare, and count = wr_ptr − rd_ptr.
- in_vld with in_rdy low: no state change. The producer must hold its data; the FIFO does not drop.

## Timing
- Reset (rstn low at an edge) forces:
  - out_vld=0, out_addr=0, out_data=0.
  - Pointers 0, count=0, empty=1, full=0, in_rdy=1.
  - gap_cnt=0, a_cnt=0, b_cnt=0.
- FIFO storage contents are not reset.
- Reset mid-operation flushes all queued entries; nothing is issued on the reset edge or the edge following it.
- Latency: a word accepted at edge k into an empty FIFO, with out_en=1 and gap_cnt=0, gives out_vld high in cycle k+1..k+2 (set at edge k+1).
- Throughput:
  - GAP=0: one issue per cycle sustained.
  - GAP=g: at most one issue every g+1 cycles.
- count, full and empty are registered state and update on the same edge as the push/pop that changes them.
- out_en is sampled at the pop edge only. Deasserting it takes effect on the next edge; an already-asserted out_vld completes.

## Test plan
- Reset then single push {addr=8'h10,data=16'hBEEF}, out_en=1, GAP=0 → out_vld pulses exactly one cycle, at the edge after the push, with addr 8'h10 / data 16'hBEEF; a_cnt=1, b_cnt=0; empty returns to 1.
- out_en=0, push DEPTH=8 words 0..7 → count=8, full=1, in_rdy=0; a 9th in_vld is held with no state change. Then out_en=1 → 8 consecutive out_vld pulses in order 0..7, and in_rdy rises the cycle after the first pop.
- GAP=2, 4 queued words → out_vld high on cycles n, n+3, n+6, n+9 only.
- Continuous push and pop at one word per cycle with GAP=0 → count stays constant at 1 and output order matches input order.
- Addresses 8'h3F, 8'h40, 8'h00, 8'hFF issued → a_cnt=2, b_cnt=2. Separately, preload b_cnt to 16'hFFFF via 65535 issues, then issue one more → b_cnt=0.
- Assert rstn low while count=5 and issuing → on the reset edge all outputs are zero and count=0. After release, no out_vld occurs until a new push.

Source files
------------

// File: rtl/switch_ingress_fifo.sv
// switch_ingress_fifo
//   Buffered ingress stage in front of the two-way address switch. A producer
//   pushes {addr,data} over a valid/ready handshake into a DEPTH-entry FIFO.
//   Entries are issued to the switch as single-cycle out_vld pulses. Issue is
//   throttled by out_en and by a programmable inter-issue gap. Wrapping
//   per-destination issue counters are split at ADDR_DIV.
//
// Ports
//   clk       clock, all logic on posedge
//   rstn      synchronous active-low reset
//   in_vld    producer has a transaction
//   in_rdy    FIFO can accept (== !full)
//   in_addr   transaction address
//   in_data   transaction data
//   out_en    downstream issue enable, low stalls issue
//   out_vld   one-cycle issue strobe to switch vld
//   out_addr  issued address to switch addr
//   out_data  issued data to switch data
//   count     current occupancy, 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
//   a_cnt     issues with addr <= ADDR_DIV, wrapping
//   b_cnt     issues with addr >  ADDR_DIV, wrapping
module switch_ingress_fifo #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 8,
  parameter int                    GAP        = 0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DIV   = 8'h3F
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      out_en,
  output logic                      out_vld,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic [15:0]               a_cnt,
  output logic [15:0]               b_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  // Gap counter is at least one bit wide so GAP=0 still elaborates cleanly.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1);

  logic [EW-1:0]         mem [DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [GW-1:0]         gap_cnt;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  // Pointers carry an extra wrap bit: equal pointers mean empty, equal index
  // with differing wrap bits means full.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count  = wr_ptr - rd_ptr;
  assign in_rdy = !full;

  // in_rdy ignores a same-cycle pop, so a full FIFO never accepts.
  assign push = in_vld && !full;
  assign pop  = !empty && out_en && (gap_cnt == '0);

  assign head      = mem[rd_ptr[PW-1:0]];
  assign head_addr = head[EW-1:DATA_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];

  // Storage is deliberately not reset; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= {in_addr, in_data};
    end
  end

  // The pop reads the pre-edge head, so a word written on this edge cannot
  // be issued before the next one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      gap_cnt  <= '0;
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      a_cnt    <= '0;
      b_cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        out_vld  <= 1'b1;
        out_addr <= head_addr;
        out_data <= head_data;
        gap_cnt  <= GAP_LOAD;
        if (head_addr <= ADDR_DIV) begin
          a_cnt <= a_cnt + 16'd1;
        end else begin
          b_cnt <= b_cnt + 16'd1;
        end
      end else begin
        out_vld <= 1'b0;
        // The gap drains even while out_en is low.
        if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GAP_ONE;
        end
      end
    end
  end

endmodule
